// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared definitions for the 68000 bus master.
//  - SIZE_* request size encodings (3 = reserved, handled as a word)
//  - state_e: bus-cycle sequencer states
//  - bus_regs_t: all registered sequencer outputs/context, plus its reset value
//  - ds_strobes(): {UDS_N, LDS_N} for a given size and byte address bit 0
package m68k_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_WORD = 2'd1;
  localparam logic [1:0] SIZE_LONG = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SETUP, ST_AS, ST_DS, ST_WAIT, ST_DELAY, ST_LATCH, ST_END, ST_DONE
  } state_e;

  typedef struct packed {
    logic [22:0] a;
    logic [2:0]  fc;
    logic        rw;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        d_oe;
    logic [15:0] d_out;
    logic [31:0] data_in;
    logic        clear;
    logic        second;
    logic        error;
    logic        addr0;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [7:0]  cnt;
    logic        await_drop;
  } bus_regs_t;

  localparam bus_regs_t BUS_REGS_RESET = '{
    a: '0, fc: '0, rw: 1'b1, as_n: 1'b1, uds_n: 1'b1, lds_n: 1'b1, d_oe: 1'b0,
    d_out: '0, data_in: '0, clear: 1'b0, second: 1'b0, error: 1'b1, addr0: 1'b0,
    size: '0, wdata: '0, cnt: '0, await_drop: 1'b0
  };

  // Byte accesses use UDS for even addresses (D[15:8]) and LDS for odd ones.
  function automatic logic [1:0] ds_strobes(input logic [1:0] size, input logic a0);
    if (size == SIZE_BYTE) return a0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

endpackage

// File: rtl/clk7_edge_sync.sv
// clk7_edge_sync: synchronizes the asynchronous 68k bus inputs into sysclk.
//  Params: SYNC_STAGES (>=2) flip-flop depth.
//  Ports : sysclk, rst_n (sync, active low), clk7, dtack_n, berr_n (async in);
//          clk7_rise/clk7_fall one-sysclk strobes, dtack_n_s/berr_n_s synchronized levels.
module clk7_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clk7,
  input  logic dtack_n,
  input  logic berr_n,
  output logic clk7_rise,
  output logic clk7_fall,
  output logic dtack_n_s,
  output logic berr_n_s
);

  logic [SYNC_STAGES-1:0] clk7_sr;
  logic [SYNC_STAGES-1:0] dtack_sr;
  logic [SYNC_STAGES-1:0] berr_sr;
  logic                   clk7_prev;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      clk7_sr   <= '0;
      dtack_sr  <= '1;
      berr_sr   <= '1;
      clk7_prev <= 1'b0;
    end else begin
      clk7_sr   <= {clk7_sr[SYNC_STAGES-2:0], clk7};
      dtack_sr  <= {dtack_sr[SYNC_STAGES-2:0], dtack_n};
      berr_sr   <= {berr_sr[SYNC_STAGES-2:0], berr_n};
      clk7_prev <= clk7_sr[SYNC_STAGES-1];
    end
  end

  assign clk7_rise = clk7_sr[SYNC_STAGES-1] & ~clk7_prev;
  assign clk7_fall = ~clk7_sr[SYNC_STAGES-1] & clk7_prev;
  assign dtack_n_s = dtack_sr[SYNC_STAGES-1];
  assign berr_n_s  = berr_sr[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: runs 68000 bus cycles on behalf of the Pi request interface.
//  Params: SYNC_STAGES (CLK7/DTACK_N/BERR_N sync depth), ADDR_SETUP (extra cycles
//          from address valid to AS_N).
//  Request side: REQUEST_* in, REQUEST_DATA_IN / CLEAR_ACTIVE / SECOND_CYCLE / ERROR out.
//  Bus side: M68K_A/FC/RW/AS_N/UDS_N/LDS_N/D_OUT/D_OE out, M68K_D_IN/DTACK_N/BERR_N in.
//  Optional macro M68K_BERR_EN: honour BERR_N (ERROR goes low); otherwise ERROR stays 1.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_SETUP  = 1
) (
  input  logic        SYSCLK,
  input  logic        RST_N,
  input  logic        CLK7,
  input  logic        REQUEST_ACTIVE,
  input  logic [23:0] REQUEST_ADDRESS,
  input  logic [31:0] REQUEST_DATA_OUT,
  input  logic [2:0]  REQUEST_FC,
  input  logic [1:0]  REQUEST_SIZE,
  input  logic        REQUEST_IS_READ,
  input  logic [7:0]  DTACK_DELAY,
  output logic [31:0] REQUEST_DATA_IN,
  output logic        CLEAR_ACTIVE,
  output logic        SECOND_CYCLE,
  output logic        ERROR,
  output logic [22:0] M68K_A,
  output logic [2:0]  M68K_FC,
  output logic        M68K_RW,
  output logic        M68K_AS_N,
  output logic        M68K_UDS_N,
  output logic        M68K_LDS_N,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  input  logic [15:0] M68K_D_IN,
  input  logic        M68K_DTACK_N,
  input  logic        M68K_BERR_N
);

  logic clk7_rise, clk7_fall, dtack_n_s, berr_n_s;

  clk7_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sysclk    (SYSCLK),
    .rst_n     (RST_N),
    .clk7      (CLK7),
    .dtack_n   (M68K_DTACK_N),
    .berr_n    (M68K_BERR_N),
    .clk7_rise (clk7_rise),
    .clk7_fall (clk7_fall),
    .dtack_n_s (dtack_n_s),
    .berr_n_s  (berr_n_s)
  );

`ifndef M68K_BERR_EN
  logic unused_berr;
  assign unused_berr = berr_n_s;
`endif

  state_e    state_q, state_d;
  bus_regs_t r, r_d;
  logic      first_of_long;
  logic [15:0] wr_word;

  assign first_of_long = (r.size == SIZE_LONG) && !r.second;

  always_comb begin
    wr_word = r.wdata[15:0];
    if (r.size == SIZE_BYTE)  wr_word = {2{r.wdata[7:0]}};
    else if (first_of_long)   wr_word = r.wdata[31:16];
  end

  always_ff @(posedge SYSCLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      r       <= BUS_REGS_RESET;
    end else begin
      state_q <= state_d;
      r       <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r;
    r_d.clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // After a completion, wait for the requester to drop REQUEST_ACTIVE.
        if (r.await_drop) begin
          if (!REQUEST_ACTIVE) r_d.await_drop = 1'b0;
        end else if (REQUEST_ACTIVE) begin
          r_d.a      = REQUEST_ADDRESS[23:1];
          r_d.addr0  = REQUEST_ADDRESS[0];
          r_d.fc     = REQUEST_FC;
          r_d.rw     = REQUEST_IS_READ;
          r_d.size   = REQUEST_SIZE;
          r_d.wdata  = REQUEST_DATA_OUT;
          r_d.error  = 1'b1;
          r_d.second = 1'b0;
          r_d.cnt    = 8'(ADDR_SETUP);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r.cnt != '0) begin
          r_d.cnt = r.cnt - 8'd1;
        end else if (clk7_fall) begin
          r_d.as_n = 1'b0;
          if (r.rw) begin
            {r_d.uds_n, r_d.lds_n} = ds_strobes(r.size, r.addr0);
          end else begin
            r_d.d_oe  = 1'b1;
            r_d.d_out = wr_word;
          end
          state_d = ST_AS;
        end
      end
      ST_AS: begin
        if (clk7_fall) begin
          {r_d.uds_n, r_d.lds_n} = ds_strobes(r.size, r.addr0);
          state_d = ST_DS;
        end
      end
      ST_DS, ST_WAIT: begin
        if (clk7_fall) begin
          if (!dtack_n_s) begin
            if (DTACK_DELAY == '0) begin
              state_d = ST_LATCH;
            end else begin
              r_d.cnt = DTACK_DELAY;
              state_d = ST_DELAY;
            end
          end else begin
            state_d = ST_WAIT;
          end
`ifdef M68K_BERR_EN
          // Bus error overrides DTACK; error also suppresses the second half.
          if (!berr_n_s) begin
            r_d.error = 1'b0;
            r_d.as_n  = 1'b1;
            r_d.uds_n = 1'b1;
            r_d.lds_n = 1'b1;
            state_d   = ST_END;
          end
`endif
        end
      end
      ST_DELAY: begin
        if (r.cnt <= 8'd1) state_d = ST_LATCH;
        else               r_d.cnt = r.cnt - 8'd1;
      end
      ST_LATCH: begin
        if (clk7_fall) begin
          if (r.rw) begin
            if (r.size == SIZE_BYTE)
              r_d.data_in = {24'h0, r.addr0 ? M68K_D_IN[7:0] : M68K_D_IN[15:8]};
            else if (first_of_long)
              r_d.data_in[31:16] = M68K_D_IN;
            else if (r.size == SIZE_LONG)
              r_d.data_in[15:0] = M68K_D_IN;
            else
              r_d.data_in = {16'h0, M68K_D_IN};
          end
          r_d.as_n  = 1'b1;
          r_d.uds_n = 1'b1;
          r_d.lds_n = 1'b1;
          state_d   = ST_END;
        end
      end
      ST_END: begin
        // Entered on the cycle strobes negate, so D_OE drops one cycle later.
        r_d.d_oe = 1'b0;
        if (first_of_long && r.error) begin
          if (clk7_rise) begin
            r_d.second = 1'b1;
            r_d.a      = r.a + 23'd1;
            r_d.cnt    = 8'(ADDR_SETUP);
            state_d    = ST_SETUP;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        r_d.clear      = 1'b1;
        r_d.second     = 1'b0;
        r_d.rw         = 1'b1;
        r_d.await_drop = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign REQUEST_DATA_IN = r.data_in;
  assign CLEAR_ACTIVE    = r.clear;
  assign SECOND_CYCLE    = r.second;
  assign ERROR           = r.error;
  assign M68K_A          = r.a;
  assign M68K_FC         = r.fc;
  assign M68K_RW         = r.rw;
  assign M68K_AS_N       = r.as_n;
  assign M68K_UDS_N      = r.uds_n;
  assign M68K_LDS_N      = r.lds_n;
  assign M68K_D_OUT      = r.d_out;
  assign M68K_D_OE       = r.d_oe;

endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: directed requests; expected bus cycles and completions are
// queued at issue time and checked by a bus-slave monitor and a completion monitor.
module tb_m68k_bus_master;

  logic        SYSCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CLK7 = 1'b0;
  logic        REQUEST_ACTIVE = 1'b0;
  logic [23:0] REQUEST_ADDRESS = '0;
  logic [31:0] REQUEST_DATA_OUT = '0;
  logic [2:0]  REQUEST_FC = '0;
  logic [1:0]  REQUEST_SIZE = '0;
  logic        REQUEST_IS_READ = 1'b1;
  logic [7:0]  DTACK_DELAY = '0;
  logic [31:0] REQUEST_DATA_IN;
  logic        CLEAR_ACTIVE, SECOND_CYCLE, ERROR;
  logic [22:0] M68K_A;
  logic [2:0]  M68K_FC;
  logic        M68K_RW, M68K_AS_N, M68K_UDS_N, M68K_LDS_N, M68K_D_OE;
  logic [15:0] M68K_D_OUT;
  logic [15:0] M68K_D_IN = '0;
  logic        M68K_DTACK_N = 1'b1;
  logic        M68K_BERR_N = 1'b1;

  m68k_bus_master #(.SYNC_STAGES(2), .ADDR_SETUP(1)) dut (
    .SYSCLK(SYSCLK), .RST_N(RST_N), .CLK7(CLK7),
    .REQUEST_ACTIVE(REQUEST_ACTIVE), .REQUEST_ADDRESS(REQUEST_ADDRESS),
    .REQUEST_DATA_OUT(REQUEST_DATA_OUT), .REQUEST_FC(REQUEST_FC),
    .REQUEST_SIZE(REQUEST_SIZE), .REQUEST_IS_READ(REQUEST_IS_READ),
    .DTACK_DELAY(DTACK_DELAY), .REQUEST_DATA_IN(REQUEST_DATA_IN),
    .CLEAR_ACTIVE(CLEAR_ACTIVE), .SECOND_CYCLE(SECOND_CYCLE), .ERROR(ERROR),
    .M68K_A(M68K_A), .M68K_FC(M68K_FC), .M68K_RW(M68K_RW),
    .M68K_AS_N(M68K_AS_N), .M68K_UDS_N(M68K_UDS_N), .M68K_LDS_N(M68K_LDS_N),
    .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE), .M68K_D_IN(M68K_D_IN),
    .M68K_DTACK_N(M68K_DTACK_N), .M68K_BERR_N(M68K_BERR_N)
  );

  always #5 SYSCLK = ~SYSCLK;
  initial begin
    #3;
    forever #40 CLK7 = ~CLK7;
  end

  typedef struct {
    logic [22:0] a;
    logic [2:0]  fc;
    logic        uds_n, lds_n, rw, second, berr;
    logic [15:0] dout, rdata;
  } bus_t;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];

  int n_assert = 0;
  int n_fail   = 0;
  int dtack_wait = 2;
  int gap_min    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic exp_cycle(input logic [22:0] a, input logic [2:0] fc, input logic uds_n,
                           input logic lds_n, input logic rw, input logic second,
                           input logic berr, input logic [15:0] dout, input logic [15:0] rdata);
    bus_t b;
    b.a = a; b.fc = fc; b.uds_n = uds_n; b.lds_n = lds_n; b.rw = rw;
    b.second = second; b.berr = berr; b.dout = dout; b.rdata = rdata;
    exp_bus.push_back(b);
  endtask

  task automatic exp_complete(input logic [31:0] data, input logic err);
    done_t d;
    d.data = data; d.err = err;
    exp_done.push_back(d);
  endtask

  task automatic req(input logic [23:0] addr, input logic [31:0] data, input logic [2:0] fc,
                     input logic [1:0] size, input logic rd, input logic [7:0] dly);
    @(negedge SYSCLK);
    REQUEST_ADDRESS  = addr;
    REQUEST_DATA_OUT = data;
    REQUEST_FC       = fc;
    REQUEST_SIZE     = size;
    REQUEST_IS_READ  = rd;
    DTACK_DELAY      = dly;
    REQUEST_ACTIVE   = 1'b1;
  endtask

  task automatic finish_req();
    bit seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge SYSCLK);
      if (CLEAR_ACTIVE) begin
        seen = 1'b1;
        break;
      end
    end
    chk("clear_seen", 32'(seen), 32'd1);
    REQUEST_ACTIVE = 1'b0;
    repeat (3) @(negedge SYSCLK);
  endtask

  // Bus slave + bus-cycle monitor.
  int  nedge = 0;
  int  ds_cnt = 0;
  int  ack_edge = 0;
  bit  acked = 1'b0;
  bit  as_prev = 1'b1;
  bit  oe_phase = 1'b0;
  always @(negedge SYSCLK) begin
    bus_t b;
    nedge++;
    if (!RST_N) begin
      M68K_DTACK_N = 1'b1;
      M68K_BERR_N  = 1'b1;
      ds_cnt = 0; acked = 1'b0; as_prev = 1'b1; oe_phase = 1'b0;
    end else begin
      if (oe_phase) begin
        chk("d_oe_released", 32'(M68K_D_OE), 32'd0);
        oe_phase = 1'b0;
      end
      if (M68K_AS_N && !as_prev) begin
        chk("as_held_until_ack", 32'(acked), 32'd1);
        chk("d_oe_after_as", 32'(M68K_D_OE), 32'(!M68K_RW));
        oe_phase = 1'b1;
        if (gap_min != 0) chk("latch_gap_ok", 32'((nedge - ack_edge) >= gap_min), 32'd1);
      end
      as_prev = M68K_AS_N;
      if (M68K_AS_N) begin
        M68K_DTACK_N = 1'b1;
        M68K_BERR_N  = 1'b1;
        ds_cnt = 0;
        acked  = 1'b0;
      end else if (!(M68K_UDS_N && M68K_LDS_N) && !acked) begin
        ds_cnt++;
        if (ds_cnt >= dtack_wait) begin
          acked    = 1'b1;
          ack_edge = nedge;
          chk("bus_cycle_expected", 32'(exp_bus.size() > 0), 32'd1);
          if (exp_bus.size() > 0) begin
            b = exp_bus.pop_front();
            chk("bus_a", 32'(M68K_A), 32'(b.a));
            chk("bus_fc", 32'(M68K_FC), 32'(b.fc));
            chk("bus_uds_n", 32'(M68K_UDS_N), 32'(b.uds_n));
            chk("bus_lds_n", 32'(M68K_LDS_N), 32'(b.lds_n));
            chk("bus_rw", 32'(M68K_RW), 32'(b.rw));
            chk("bus_second", 32'(SECOND_CYCLE), 32'(b.second));
            chk("bus_d_oe", 32'(M68K_D_OE), 32'(!b.rw));
            if (!b.rw) chk("bus_d_out", 32'(M68K_D_OUT), 32'(b.dout));
            M68K_D_IN = b.rdata;
            if (b.berr) M68K_BERR_N = 1'b0;
            else        M68K_DTACK_N = 1'b0;
          end
        end
      end
    end
  end

  // Completion monitor.
  bit clear_prev = 1'b0;
  always @(negedge SYSCLK) begin
    done_t d;
    if (RST_N && CLEAR_ACTIVE) begin
      chk("clear_width", 32'(clear_prev), 32'd0);
      chk("clear_expected", 32'(exp_done.size() > 0), 32'd1);
      chk("second_low_at_clear", 32'(SECOND_CYCLE), 32'd0);
      if (exp_done.size() > 0) begin
        d = exp_done.pop_front();
        chk("data_in", REQUEST_DATA_IN, d.data);
        chk("error", 32'(ERROR), 32'(d.err));
      end
    end
    clear_prev = CLEAR_ACTIVE;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (5) @(negedge SYSCLK);
    RST_N = 1'b1;
    repeat (2) @(negedge SYSCLK);
    chk("rst_as_n", 32'(M68K_AS_N), 32'd1);
    chk("rst_uds_n", 32'(M68K_UDS_N), 32'd1);
    chk("rst_lds_n", 32'(M68K_LDS_N), 32'd1);
    chk("rst_rw", 32'(M68K_RW), 32'd1);
    chk("rst_d_oe", 32'(M68K_D_OE), 32'd0);
    chk("rst_a", 32'(M68K_A), 32'd0);
    chk("rst_fc", 32'(M68K_FC), 32'd0);
    chk("rst_clear", 32'(CLEAR_ACTIVE), 32'd0);
    chk("rst_second", 32'(SECOND_CYCLE), 32'd0);
    chk("rst_error", 32'(ERROR), 32'd1);
    chk("rst_data_in", REQUEST_DATA_IN, 32'd0);

    // Word read 0xDFF006.
    exp_cycle(23'h6FF803, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1234);
    exp_complete(32'h0000_1234, 1'b1);
    req(24'hDFF006, 32'h0, 3'd5, 2'd1, 1'b1, 8'd0);
    finish_req();

    // Byte write to odd address: only LDS, data replicated.
    exp_cycle(23'h000000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0);
    exp_complete(32'h0000_1234, 1'b1);
    req(24'h000001, 32'h1234_56A5, 3'd1, 2'd0, 1'b0, 8'd0);
    finish_req();

    // Long read wrapping to address 0.
    exp_cycle(23'h7FFFFF, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'hDEAD);
    exp_cycle(23'h000000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'hBEEF);
    exp_complete(32'hDEAD_BEEF, 1'b1);
    req(24'hFFFFFE, 32'h0, 3'd5, 2'd2, 1'b1, 8'd0);
    finish_req();

    // Byte read even address: UDS only, D[15:8].
    exp_cycle(23'h000008, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h5A77);
    exp_complete(32'h0000_005A, 1'b1);
    req(24'h000010, 32'h0, 3'd2, 2'd0, 1'b1, 8'd0);
    finish_req();

    // Long write: high word then low word.
    exp_cycle(23'h000080, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCAFE, 16'h0);
    exp_cycle(23'h000081, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF00D, 16'h0);
    exp_complete(32'h0000_005A, 1'b1);
    req(24'h000100, 32'hCAFE_F00D, 3'd1, 2'd2, 1'b0, 8'd0);
    finish_req();

    // Reserved size 3 behaves as a word.
    exp_cycle(23'h0000A0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h8001);
    exp_complete(32'h0000_8001, 1'b1);
    req(24'h000141, 32'h0, 3'd5, 2'd3, 1'b1, 8'd0);
    finish_req();

    // Slow DTACK (3 CLK7 periods) with DTACK_DELAY=5.
    dtack_wait = 24;
    gap_min    = 7;
    exp_cycle(23'h000100, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0F0F);
    exp_complete(32'h0000_0F0F, 1'b1);
    req(24'h000200, 32'h0, 3'd5, 2'd1, 1'b1, 8'd5);
    finish_req();
    dtack_wait = 2;
    gap_min    = 0;

`ifdef M68K_BERR_EN
    // Bus error on first half of a long write: one cycle only, ERROR low.
    exp_cycle(23'h000180, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1357, 16'h0);
    exp_complete(32'h0000_0F0F, 1'b0);
    req(24'h000300, 32'h1357_2468, 3'd1, 2'd2, 1'b0, 8'd0);
    finish_req();
    exp_cycle(23'h000181, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1111);
    exp_complete(32'h0000_1111, 1'b1);
    req(24'h000302, 32'h0, 3'd5, 2'd1, 1'b1, 8'd0);
    finish_req();
`endif

    // Reset while AS_N is asserted, request still pending afterwards.
    exp_cycle(23'h000200, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h2222);
    exp_complete(32'h0000_2222, 1'b1);
    dtack_wait = 1_000_000;
    req(24'h000400, 32'h0, 3'd5, 2'd1, 1'b1, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge SYSCLK);
      if (!M68K_AS_N) begin
        seen = 1'b1;
        break;
      end
    end
    chk("as_before_reset", 32'(seen), 32'd1);
    @(negedge SYSCLK);
    RST_N = 1'b0;
    @(negedge SYSCLK);
    chk("abort_as_n", 32'(M68K_AS_N), 32'd1);
    chk("abort_uds_n", 32'(M68K_UDS_N), 32'd1);
    chk("abort_lds_n", 32'(M68K_LDS_N), 32'd1);
    chk("abort_no_clear", 32'(CLEAR_ACTIVE), 32'd0);
    repeat (3) @(negedge SYSCLK);
    dtack_wait = 2;
    RST_N = 1'b1;
    finish_req();

    chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
